sram_rr_ctrl: RTL

- Sequencer and arbiter for a 256x16 masked-write, 1R1W SRAM macro with 1-cycle registered read latency.
- After reset, or on request, it walks the whole array clearing it to zero. It then shares the single read port between two requesters, using round-robin, and passes one masked write port through.
- Sits between pipeline-side requesters and the SRAM macro; owns all macro enables.

---
 rtl/sram_rr_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sram_rr_ctrl.sv
// Clear sequencer and round-robin 2-reader/1-writer front end for a masked 1R1W SRAM macro.
// Optional SRAM_RR_CTRL_HOLD_READ_EN: per-reader response data holds its last value between responses.
module sram_rr_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int MASK_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear_req,
   output logic              init_done,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [MASK_W-1:0] w_mask,
   input  logic              r0_valid,
   input  logic              r1_valid,
   output logic              r0_ready,
   output logic              r1_ready,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [ADDR_W-1:0] r1_addr,
   output logic              r0_resp_valid,
   output logic              r1_resp_valid,
   output logic [DATA_W-1:0] r0_resp_data,
   output logic [DATA_W-1:0] r1_resp_data,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_rr;            // 1: r1 wins when both readers are valid
   logic              r_resp0_valid;
   logic              r_resp1_valid;

   logic              w_sel;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_any;
   logic              w_conflict;
   logic              w_grant;

   assign w_any      = r0_valid | r1_valid;
   assign w_sel      = (r1_valid & ~r0_valid) | (r0_valid & r1_valid & r_rr);
   assign w_sel_addr = w_sel ? r1_addr : r0_addr;
   // A read colliding with a same-cycle write is held back so it observes the new data.
   assign w_conflict = w_valid & (w_sel_addr == w_addr);
   assign w_grant    = (r_state == ST_RUN) & w_any & ~w_conflict;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_INIT;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_INIT: if (r_cnt == LAST_ADDR) w_next_state = ST_RUN;
         ST_RUN:  if (clear_req)          w_next_state = ST_INIT;
         default: w_next_state = ST_INIT;
      endcase
   end

   always_comb begin
      init_done = 1'b0;
      w_ready   = 1'b0;
      r0_ready  = 1'b0;
      r1_ready  = 1'b0;
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      mem_ren   = 1'b0;
      mem_raddr = '0;
      case (r_state)
         ST_INIT: begin
            // Reset is folded in so the macro sees no write while reset is held.
            mem_wen   = reset_n;
            mem_waddr = r_cnt;
            mem_wmask = '1;
         end
         ST_RUN: begin
            init_done = 1'b1;
            w_ready   = 1'b1;
            mem_wen   = w_valid;
            mem_waddr = w_addr;
            mem_wdata = w_data;
            mem_wmask = w_mask;
            r0_ready  = w_grant & ~w_sel;
            r1_ready  = w_grant & w_sel;
            mem_ren   = w_grant;
            mem_raddr = w_sel_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt         <= '0;
         r_rr          <= 1'b0;
         r_resp0_valid <= 1'b0;
         r_resp1_valid <= 1'b0;
      end else begin
         r_cnt         <= (r_state == ST_INIT) ? r_cnt + 1'b1 : '0;
         if (w_grant) r_rr <= ~w_sel;
         r_resp0_valid <= w_grant & ~w_sel;
         r_resp1_valid <= w_grant & w_sel;
      end
   end

   assign r0_resp_valid = r_resp0_valid;
   assign r1_resp_valid = r_resp1_valid;

`ifdef SRAM_RR_CTRL_HOLD_READ_EN
   logic [DATA_W-1:0] r_hold0;
   logic [DATA_W-1:0] r_hold1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold0 <= '0;
         r_hold1 <= '0;
      end else begin
         if (r_resp0_valid) r_hold0 <= mem_rdata;
         if (r_resp1_valid) r_hold1 <= mem_rdata;
      end
   end

   assign r0_resp_data = r_resp0_valid ? mem_rdata : r_hold0;
   assign r1_resp_data = r_resp1_valid ? mem_rdata : r_hold1;
`else
   assign r0_resp_data = r_resp0_valid ? mem_rdata : '0;
   assign r1_resp_data = r_resp1_valid ? mem_rdata : '0;
`endif

endmodule
